// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the sequential shift unit: operation encodings and
// the controller state type.
// No ports.
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// ----------------------------------------------------------------------------
// shift_step
// Combinational shifter: shifts a WIDTH-bit value by 0..MAX_AMT bits using
// one of the four shift operations.
// Ports:
//   op     in  2      operation (OP_SLL / OP_SRL / OP_SRA / OP_ROL)
//   data   in  WIDTH  value to shift
//   amt    in  AMT_W  shift amount, 0..MAX_AMT
//   result out WIDTH  shifted value
// ----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_AMT = 1,
    parameter int AMT_W   = $clog2(MAX_AMT + 1)
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] result
);

    // Rotate: shift a doubled copy left; the upper half holds the rotated word.
    logic [2*WIDTH-1:0] rot;

    always_comb begin
        rot    = {data, data} << amt;
        result = data;
        case (op)
            OP_SLL:  result = data << amt;
            OP_SRL:  result = data >> amt;
            OP_SRA:  result = $signed(data) >>> amt;
            default: result = rot[2*WIDTH-1:WIDTH];
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// ----------------------------------------------------------------------------
// seq_shifter
// Multi-cycle shift unit (SLL / SRL / SRA / ROL) with valid/ready handshakes.
// Shifts STEP bits per cycle; with SEQ_SHIFTER_FAST_EN defined a single-cycle
// barrel shifter is used instead and the SHIFT state is never entered.
//
// Ports:
//   CLK        in   1        clock, rising edge
//   RST_N      in   1        asynchronous active-low reset
//   in_valid   in   1        request valid
//   in_ready   out  1        unit can accept a request (IDLE)
//   op         in   2        operation
//   data_in    in   WIDTH    operand
//   shamt      in   SHAMT_W  shift amount
//   out_valid  out  1        result valid (DONE)
//   out_ready  in   1        consumer accepts result
//   data_out   out  WIDTH    result, held after the output handshake
//   busy       out  1        shifting in progress (SHIFT)
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, in_ready high
// SHIFT  | work register shifted min(STEP, rem) bits per cycle
// DONE   | result on data_out, waiting for out_ready
// ----------------------------------------------------------------------------
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy
);

    state_e state;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SHIFT);

`ifdef SEQ_SHIFTER_FAST_EN

    logic [WIDTH-1:0] fast_res;

    shift_step #(
        .WIDTH   (WIDTH),
        .MAX_AMT (WIDTH - 1),
        .AMT_W   (SHAMT_W)
    ) u_step (
        .op     (op),
        .data   (data_in),
        .amt    (shamt),
        .result (fast_res)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_out <= fast_res;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`else

    localparam int STEP_AW = $clog2(STEP + 1);
    localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W + 1)'(STEP);

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W:0]   rem_ext;
    logic [SHAMT_W:0]   s_full;
    logic [STEP_AW-1:0] step_amt;
    logic [WIDTH-1:0]   step_res;
    logic               last_step;

    // Extended by one bit so STEP == WIDTH still compares correctly.
    always_comb begin
        rem_ext   = {1'b0, rem};
        s_full    = (rem_ext < STEP_EXT) ? rem_ext : STEP_EXT;
        step_amt  = s_full[STEP_AW-1:0];
        last_step = (rem_ext == s_full);
    end

    shift_step #(
        .WIDTH   (WIDTH),
        .MAX_AMT (STEP),
        .AMT_W   (STEP_AW)
    ) u_step (
        .op     (op_q),
        .data   (work),
        .amt    (step_amt),
        .result (step_res)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            data_out <= '0;
            op_q     <= OP_SLL;
            work     <= '0;
            rem      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        work <= data_in;
                        rem  <= shamt;
                        if (shamt == '0) begin
                            data_out <= data_in;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step_res;
                    rem  <= rem - s_full[SHAMT_W-1:0];
                    if (last_step) begin
                        data_out <= step_res;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_seq_shifter.sv
// ----------------------------------------------------------------------------
// tb_seq_shifter
// Self-checking bench for seq_shifter. Two instances (STEP=1 and STEP=4)
// receive the same requests; results and latencies are compared against a
// arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  shamt = 4'h0;
    logic        out_ready = 1'b1;

    logic        in_ready1, out_valid1, busy1;
    logic [15:0] data_out1;
    logic        in_ready4, out_valid4, busy4;
    logic [15:0] data_out4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    seq_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .data_in(data_in), .shamt(shamt), .out_valid(out_valid1),
        .out_ready(out_ready), .data_out(data_out1), .busy(busy1)
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .data_in(data_in), .shamt(shamt), .out_valid(out_valid4),
        .out_ready(out_ready), .data_out(data_out4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] d, input int s);
        int unsigned v;
        int          sv;
        logic [31:0] r;
        v  = d;
        sv = int'($signed(d));
        case (o)
            2'd0:    r = v << s;
            2'd1:    r = v >> s;
            2'd2:    r = sv >>> s;
            default: r = (v << s) | (v >> (16 - s));
        endcase
        return r[15:0];
    endfunction

    function automatic int cycles(input int s, input int step);
        return FAST ? 0 : (s + step - 1) / step;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout1"}, data_out1, 0);
        chk({tag, "_ov1"}, out_valid1, 0);
        chk({tag, "_rdy1"}, in_ready1, 1);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_dout4"}, data_out4, 0);
        chk({tag, "_ov4"}, out_valid4, 0);
        chk({tag, "_rdy4"}, in_ready4, 1);
        chk({tag, "_busy4"}, busy4, 0);
    endtask

    task automatic do_txn(input logic [1:0] o, input logic [15:0] d, input logic [3:0] s);
        logic [15:0] e;
        int k1, k4, cnt, b1, b4;
        bit g1, g4;
        e  = model(o, d, int'(s));
        k1 = cycles(int'(s), 1);
        k4 = cycles(int'(s), 4);
        @(negedge CLK);
        op = o; data_in = d; shamt = s; in_valid = 1'b1; out_ready = 1'b1;
        chk("in_ready1", in_ready1, 1);
        chk("in_ready4", in_ready4, 1);
        @(posedge CLK); #1;
        // Inputs after acceptance must not matter.
        in_valid = 1'b0;
        op = 2'($urandom); data_in = 16'($urandom); shamt = 4'($urandom);
        cnt = 1; g1 = 0; g4 = 0; b1 = 0; b4 = 0;
        while (!(g1 && g4) && cnt <= 40) begin
            if (!g1) begin
                if (busy1) b1++;
                if (out_valid1) begin
                    g1 = 1;
                    chk("lat1", cnt, k1 + 1);
                    chk("data1", data_out1, e);
                    chk("busy1", b1, k1);
                end
            end
            if (!g4) begin
                if (busy4) b4++;
                if (out_valid4) begin
                    g4 = 1;
                    chk("lat4", cnt, k4 + 1);
                    chk("data4", data_out4, e);
                    chk("busy4", b4, k4);
                end
            end
            if (!(g1 && g4)) begin
                @(posedge CLK); #1;
                cnt++;
            end
        end
        if (!g1) chk("timeout1", 0, 1);
        if (!g4) chk("timeout4", 0, 1);
        @(posedge CLK); #1;
        chk("post_ov1", out_valid1, 0);
        chk("post_rdy4", in_ready4, 1);
        chk("post_dout1", data_out1, e);
    endtask

    initial begin
        logic [15:0] e;
        int cnt;

        // Reset state
        #1;
        chk_reset_outputs("rst");
        @(negedge CLK);
        RST_N = 1'b1;

        // Directed vectors
        do_txn(2'd0, 16'h00AB, 4'd8);
        do_txn(2'd2, 16'h8000, 4'd15);
        do_txn(2'd1, 16'h8000, 4'd15);
        do_txn(2'd3, 16'h8001, 4'd4);
        do_txn(2'd2, 16'h1234, 4'd0);
        do_txn(2'd0, 16'h0001, 4'd7);
        do_txn(2'd3, 16'hC003, 4'd15);
        do_txn(2'd2, 16'h7FF0, 4'd9);

        // Backpressure: hold result while a new request waits upstream
        e = model(2'd1, 16'hF0F0, 5);
        @(negedge CLK);
        op = 2'd1; data_in = 16'hF0F0; shamt = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK); #1;
        op = 2'd0; data_in = 16'h1111; shamt = 4'd1;
        cnt = 0;
        while (!(out_valid1 && out_valid4) && cnt < 40) begin
            @(posedge CLK); #1;
            cnt++;
        end
        if (cnt >= 40) chk("bp_timeout", 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ov1", out_valid1, 1);
            chk("bp_data1", data_out1, e);
            chk("bp_rdy1", in_ready1, 0);
            chk("bp_ov4", out_valid4, 1);
            chk("bp_data4", data_out4, e);
            chk("bp_rdy4", in_ready4, 0);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp_hs_rdy1", in_ready1, 1);
        chk("bp_hs_ov1", out_valid1, 0);
        chk("bp_hs_busy1", busy1, 0);
        chk("bp_hs_dout1", data_out1, e);
        chk("bp_hs_rdy4", in_ready4, 1);
        chk("bp_hs_ov4", out_valid4, 0);
        @(negedge CLK);
        in_valid = 1'b0;

        // Asynchronous reset in the 4th SHIFT cycle
        @(negedge CLK);
        op = 2'd0; data_in = 16'h00FF; shamt = 4'd8; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        chk("pre_rst_busy1", busy1, FAST ? 0 : 1);
        RST_N = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(negedge CLK);
        RST_N = 1'b1;
        out_ready = 1'b1;
        do_txn(2'd0, 16'h00FF, 4'd8);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            do_txn(2'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
